// File: rtl/fifo_sync_param_if.sv
// Bus bundle for fifo_sync_param.
//
// Handshake: the producer raises write_en with data_in. The write is taken on
// that rising edge when the FIFO is not full, or when it is full but a read is
// taken on the same edge. The consumer raises read_en, and the read is taken
// when the FIFO is not empty. Nothing is back-pressured combinationally.
// full/empty are the "ready" view, and both are registered-pointer decodes.
// A request that is not taken sets a sticky overflow or underflow flag.
// clear flushes the FIFO on an edge, and on that edge it overrides both
// requests.
//
// Modports:
//   master - producer/consumer side: drives clear, write_en, data_in and
//            read_en, and observes data and status.
//   slave  - FIFO side.
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clear;
  logic              write_en;
  logic [WIDTH-1:0]  data_in;
  logic              read_en;
  logic [WIDTH-1:0]  data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clear, write_en, data_in, read_en,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  clear, write_en, data_in, read_en,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO.
//
// This FIFO offers a registered-read mode (FWFT=0) or a first-word-fall-through
// mode (FWFT=1). It also provides an occupancy count, almost_full/almost_empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - fifo_sync_param_if.slave. It carries clear, write_en, data_in,
//            read_en, data_out, full, empty, almost_full, almost_empty,
//            count, overflow and underflow.
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               reset,
  fifo_sync_param_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_CNT   = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AE_CNT   = PTR_W'(AEMPTY_TH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  count;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              empty;
  logic              full;
  logic              rd_ok;
  logic              wr_ok;
  logic              overflow_q;
  logic              underflow_q;

  // The extra wrap bit lets the pointer difference run from 0 to DEPTH
  // without ambiguity between the full and empty cases.
  assign count   = wr_ptr - rd_ptr;
  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);

  // The read is decided first so that a full FIFO can accept a write while a
  // pop happens on the same edge. clear suppresses both accesses.
  assign rd_ok = bus.read_en & ~empty & ~bus.clear;
  assign wr_ok = bus.write_en & (~full | rd_ok) & ~bus.clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write_en && !wr_ok) overflow_q  <= 1'b1;
      if (bus.read_en  && !rd_ok) underflow_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= bus.data_in;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)     dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rd_addr];
      end

      assign bus.data_out = dout_q;
    end else begin : g_fwft
      // The head word is shown as soon as it is stored. The output is forced
      // to zero while the FIFO is empty, so that reset reads back as zero.
      assign bus.data_out = empty ? '0 : mem[rd_addr];
    end
  endgenerate

  assign bus.count        = count;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count >= AF_CNT);
  assign bus.almost_empty = (count <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param. It uses one registered-read instance (dut0) and
// one first-word-fall-through instance (dut1), and compares each against a
// queue-based model.
module tb_fifo_sync_param;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) if0 ();
  fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) if1 ();

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE))
    dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];   // dut0 model contents, head first
  logic [W-1:0] exp1_q[$];  // dut1 model contents, head first
  logic         m_ovf;
  logic         m_unf;
  logic [W-1:0] m_dout;

  // Observed dut0 status: {count, empty, full, afull, aempty, ovf, unf, data}
  logic [18:0] got0;
  assign got0 = {if0.count, if0.empty, if0.full, if0.almost_full,
                 if0.almost_empty, if0.overflow, if0.underflow, if0.data_out};

  function automatic logic [18:0] exp_vec0();
    logic [4:0] ec;
    ec = 5'(exp_q.size());
    return {ec, ec == 5'd0, ec == 5'(D), ec >= 5'(AF), ec <= 5'(AE),
            m_ovf, m_unf, m_dout};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp1_q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endtask

  // ---------------- driver tasks ----------------
  // Each task applies one edge's inputs and updates the model with queue
  // semantics. It returns 1 time unit after the edge.
  task automatic cycle0(input logic we, input logic [W-1:0] din,
                        input logic re, input logic clr);
    bit rd_ok, wr_ok;
    if0.write_en = we; if0.data_in = din; if0.read_en = re; if0.clear = clr;
    @(posedge clk);
    if (clr) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_ok = re && (exp_q.size() > 0);
      wr_ok = we && ((exp_q.size() < D) || rd_ok);
      if (rd_ok) m_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(din);
      if (we && !wr_ok) m_ovf = 1'b1;
      if (re && !rd_ok) m_unf = 1'b1;
    end
    #1;
  endtask

  task automatic cycle1(input logic we, input logic [W-1:0] din, input logic re);
    bit rd_ok, wr_ok;
    if1.write_en = we; if1.data_in = din; if1.read_en = re; if1.clear = 1'b0;
    @(posedge clk);
    rd_ok = re && (exp1_q.size() > 0);
    wr_ok = we && ((exp1_q.size() < D) || rd_ok);
    if (rd_ok) void'(exp1_q.pop_front());
    if (wr_ok) exp1_q.push_back(din);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    if0.clear = 0; if0.write_en = 0; if0.read_en = 0; if0.data_in = '0;
    if1.clear = 0; if1.write_en = 0; if1.read_en = 0; if1.data_in = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got0 !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_dut0: got %h want %h", got0,
               {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    end
    checks++;
    if ({if1.empty, if1.count, if1.data_out} !== {1'b1, 5'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_dut1: got %h want %h",
               {if1.empty, if1.count, if1.data_out}, {1'b1, 5'd0, 8'h00});
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 17; i++) begin
      cycle0(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (got0 !== exp_vec0()) begin
        errors++;
        $display("FAIL fill[%0d]: got %h want %h", i, got0, exp_vec0());
      end
    end
    checks++;
    if ({if0.full, if0.overflow, if0.count} !== {1'b1, 1'b1, 5'd16}) begin
      errors++;
      $display("FAIL fill_end: got %h want %h",
               {if0.full, if0.overflow, if0.count}, {1'b1, 1'b1, 5'd16});
    end
    for (int i = 1; i <= 17; i++) begin
      cycle0(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (got0 !== exp_vec0()) begin
        errors++;
        $display("FAIL drain[%0d]: got %h want %h", i, got0, exp_vec0());
      end
      checks++;
      if (if0.data_out !== 8'((i > 16) ? 16 : i)) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h want %h", i, if0.data_out,
                 8'((i > 16) ? 16 : i));
      end
    end
    checks++;
    if (if0.underflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_underflow: got %b want 1", if0.underflow);
    end
    cycle0(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < D; i++) cycle0(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cycle0(1'b1, 8'(k + 100), 1'b1, 1'b0);
      checks++;
      if (got0 !== exp_vec0()) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h want %h", k, got0, exp_vec0());
      end
    end
    for (int i = 0; i < D; i++) begin
      cycle0(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (got0 !== exp_vec0()) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: got %h want %h", i, got0, exp_vec0());
      end
    end
    cycle0(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_fwft();
    cycle1(1'b1, 8'hA5, 1'b0);
    checks++;
    if ({if1.empty, if1.data_out} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL fwft_first: got %h want %h", {if1.empty, if1.data_out}, {1'b0, 8'hA5});
    end
    cycle1(1'b1, 8'h3C, 1'b0);
    checks++;
    if (if1.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL fwft_hold: got %h want a5", if1.data_out);
    end
    cycle1(1'b0, '0, 1'b1);
    checks++;
    if ({if1.empty, if1.data_out} !== {1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL fwft_pop: got %h want %h", {if1.empty, if1.data_out}, {1'b0, 8'h3C});
    end
    for (int k = 0; k < 120; k++) begin
      cycle1(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
      checks++;
      if ({if1.empty, if1.count} !== {exp1_q.size() == 0, 5'(exp1_q.size())}) begin
        errors++;
        $display("FAIL fwft_status[%0d]: got %h want %h", k, {if1.empty, if1.count},
                 {exp1_q.size() == 0, 5'(exp1_q.size())});
      end
      if (exp1_q.size() > 0) begin
        checks++;
        if (if1.data_out !== exp1_q[0]) begin
          errors++;
          $display("FAIL fwft_data[%0d]: got %h want %h", k, if1.data_out, exp1_q[0]);
        end
      end
    end
    for (int i = 0; i <= D; i++) cycle1(1'b0, '0, 1'b1);
    checks++;
    if (if1.empty !== 1'b1) begin
      errors++;
      $display("FAIL fwft_drained: got %b want 1", if1.empty);
    end
    if1.read_en = 1'b0;
  endtask

  task automatic test_clear_reset();
    cycle0(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle0(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    checks++;
    if ({if0.count, if0.underflow} !== {5'd5, 1'b1}) begin
      errors++;
      $display("FAIL pre_clear: got %h want %h", {if0.count, if0.underflow}, {5'd5, 1'b1});
    end
    cycle0(1'b1, 8'hEE, 1'b0, 1'b1);
    checks++;
    if (got0 !== exp_vec0()) begin
      errors++;
      $display("FAIL clear: got %h want %h", got0, exp_vec0());
    end
    cycle0(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if ({if0.count, if0.empty, if0.overflow, if0.underflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_clear: got %h want %h",
               {if0.count, if0.empty, if0.overflow, if0.underflow}, {5'd0, 1'b1, 1'b0, 1'b0});
    end
    for (int i = 0; i < 7; i++) begin
      cycle0(1'b1, 8'($urandom_range(1, 255)), (i > 4), 1'b0);
      cycle1(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    end
    if0.write_en = 1'b0; if0.read_en = 1'b0; if1.write_en = 1'b0;
    // Assert reset between edges: the outputs must change without a clock.
    #3 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (got0 !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL async_reset_dut0: got %h want %h", got0,
               {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    end
    checks++;
    if ({if1.empty, if1.count, if1.data_out} !== {1'b1, 5'd0, 8'h00}) begin
      errors++;
      $display("FAIL async_reset_dut1: got %h want %h",
               {if1.empty, if1.count, if1.data_out}, {1'b1, 5'd0, 8'h00});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    cycle0(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (got0 !== exp_vec0()) begin
      errors++;
      $display("FAIL after_reset_read: got %h want %h", got0, exp_vec0());
    end
  endtask

  task automatic test_sweep();
    logic [18:0] prev;
    cycle0(1'b0, '0, 1'b0, 1'b1);
    for (int s = 0; s < 2 * D; s++) begin
      // Apply the next request and confirm that nothing moves before the edge.
      prev = exp_vec0();
      if0.write_en = (s < D); if0.read_en = (s >= D); if0.clear = 1'b0;
      #2;
      checks++;
      if (got0 !== prev) begin
        errors++;
        $display("FAIL lag[%0d]: got %h want %h", s, got0, prev);
      end
      cycle0(s < D, 8'($urandom_range(0, 255)), s >= D, 1'b0);
      checks++;
      if ({if0.almost_full, if0.almost_empty} !==
          {exp_q.size() >= AF, exp_q.size() <= AE}) begin
        errors++;
        $display("FAIL sweep_thresh[%0d]: got %b want %b", s,
                 {if0.almost_full, if0.almost_empty},
                 {exp_q.size() >= AF, exp_q.size() <= AE});
      end
    end
  endtask

  task automatic test_random();
    cycle0(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) begin
      cycle0(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 39) == 0));
      checks++;
      if (got0 !== exp_vec0()) begin
        errors++;
        $display("FAIL rand[%0d]: got %h want %h", k, got0, exp_vec0());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_fwft();
    test_clear_reset();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
